// File: rtl/i2c_arbiter.sv
// i2c_arbiter: shares one I2C master among NREQ requesters, using round-robin arbitration.
//
// Ports:
//   clk, reset (async, active-low)
//   r_req/r_rw/r_nbyte/r_dev_add/r_ptr/r_dwr : per-requester commands, flattened by requester index
//   r_grant (one-hot), r_done (one-cycle pulse), r_err, r_drd : responses to requesters
//   m_go/m_rw/m_nbyte/m_dev_add/m_ptr/m_dwr  : command to the I2C master
//   m_ready/m_done/m_ack_e/m_drd             : status and data from the I2C master
//
// Optional feature: define I2C_ARB_WDOG_EN to add a 16-bit per-transaction watchdog.
// The watchdog aborts a transaction after WDOG_CYC cycles in WAIT_ACC/BUSY.
module i2c_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned WDOG_CYC = 65535
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     r_req,
  input  logic [NREQ-1:0]     r_rw,
  input  logic [6*NREQ-1:0]   r_nbyte,
  input  logic [7*NREQ-1:0]   r_dev_add,
  input  logic [8*NREQ-1:0]   r_ptr,
  input  logic [8*NREQ-1:0]   r_dwr,
  output logic [NREQ-1:0]     r_grant,
  output logic [NREQ-1:0]     r_done,
  output logic                r_err,
  output logic [7:0]          r_drd,
  output logic                m_go,
  output logic                m_rw,
  output logic [5:0]          m_nbyte,
  output logic [6:0]          m_dev_add,
  output logic [7:0]          m_ptr,
  output logic [7:0]          m_dwr,
  input  logic                m_ready,
  input  logic                m_done,
  input  logic                m_ack_e,
  input  logic [7:0]          m_drd
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Reject out-of-range configurations at elaboration
  if (NREQ < 2 || NREQ > 8 || WDOG_CYC == 0 || WDOG_CYC > 65535) begin : g_bad_cfg
    $error("i2c_arbiter: NREQ must be 2..8 and WDOG_CYC 1..65535");
  end

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_ACC, BUSY, FINISH} state_t;

  state_t          state, state_d;
  logic [IW-1:0]   rr_ptr, rr_d, gidx, gidx_d;
  logic [NREQ-1:0] grant_d, done_d;
  logic            err_d, go_d, nack, nack_d, armed;
  logic            rw_d;
  logic [5:0]      nbyte_d;
  logic [6:0]      dev_d;
  logic [7:0]      ptr_d;

  // Unpacked views of the flattened per-requester fields
  logic       rw_a    [NREQ];
  logic [5:0] nbyte_a [NREQ];
  logic [6:0] dev_a   [NREQ];
  logic [7:0] ptr_a   [NREQ];
  logic [7:0] dwr_a   [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign rw_a[i]    = r_rw[i];
    assign nbyte_a[i] = r_nbyte[6*i +: 6];
    assign dev_a[i]   = r_dev_add[7*i +: 7];
    assign ptr_a[i]   = r_ptr[8*i +: 8];
    assign dwr_a[i]   = r_dwr[8*i +: 8];
  end

  // Write data follows the granted requester live; read data is shared by all
  assign m_dwr = dwr_a[gidx];
  assign r_drd = m_drd;

`ifdef I2C_ARB_WDOG_EN
  localparam logic [15:0] WDOG_LIM = 16'(WDOG_CYC - 1);
  logic [15:0] wdog, wdog_d;
`endif

  // Round-robin pick: first requester at or after rr_ptr, wrapping NREQ-1 -> 0
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW:0]   rr_sum;

  always_comb begin : rr_pick
    win_found = 1'b0;
    win_idx   = '0;
    rr_sum    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      rr_sum = {1'b0, rr_ptr} + (IW+1)'(k);
      if (rr_sum >= (IW+1)'(NREQ)) rr_sum = rr_sum - (IW+1)'(NREQ);
      if (!win_found && r_req[rr_sum[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = rr_sum[IW-1:0];
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin : next_logic
    state_d = state;
    grant_d = r_grant;
    done_d  = '0;
    err_d   = 1'b0;
    go_d    = 1'b0;
    gidx_d  = gidx;
    rr_d    = rr_ptr;
    nack_d  = nack;
    rw_d    = m_rw;
    nbyte_d = m_nbyte;
    dev_d   = m_dev_add;
    ptr_d   = m_ptr;
`ifdef I2C_ARB_WDOG_EN
    wdog_d  = wdog;
`endif
    case (state)
      IDLE: begin
        // armed delays the first arbitration to the second edge after reset release
        if (armed && m_ready && win_found) begin
          state_d = LAUNCH;
          grant_d = NREQ'(1) << win_idx;
          gidx_d  = win_idx;
          rw_d    = rw_a[win_idx];
          nbyte_d = nbyte_a[win_idx];
          dev_d   = dev_a[win_idx];
          ptr_d   = ptr_a[win_idx];
          nack_d  = 1'b0;
        end
      end
      LAUNCH: begin
        // Zero-length commands complete with an error and never reach the master
        if (m_nbyte == 6'd0) begin
          state_d = FINISH;
          done_d  = r_grant;
          err_d   = 1'b1;
          nack_d  = 1'b1;
        end else if (m_ready) begin
          state_d = WAIT_ACC;
          go_d    = 1'b1;
        end
      end
      WAIT_ACC: begin
        if (!m_done) state_d = BUSY;
      end
      BUSY: begin
        if (m_ack_e) nack_d = 1'b1;
        // m_done was low on entry, so a high level here is the 0->1 edge
        if (m_done) begin
          state_d = FINISH;
          done_d  = r_grant;
          err_d   = nack | m_ack_e;
        end
      end
      FINISH: begin
        state_d = IDLE;
        grant_d = '0;
        rr_d    = (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
      end
      default: state_d = IDLE;
    endcase
`ifdef I2C_ARB_WDOG_EN
    if (state == LAUNCH) begin
      wdog_d = '0;
    end else if (state == WAIT_ACC || state == BUSY) begin
      wdog_d = wdog + 16'd1;
      if (wdog == WDOG_LIM) begin
        state_d = FINISH;
        done_d  = r_grant;
        err_d   = 1'b1;
        nack_d  = 1'b1;
      end
    end
`endif
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      armed     <= 1'b0;
      rr_ptr    <= '0;
      gidx      <= '0;
      nack      <= 1'b0;
      r_grant   <= '0;
      r_done    <= '0;
      r_err     <= 1'b0;
      m_go      <= 1'b0;
      m_rw      <= 1'b0;
      m_nbyte   <= '0;
      m_dev_add <= '0;
      m_ptr     <= '0;
`ifdef I2C_ARB_WDOG_EN
      wdog      <= '0;
`endif
    end else begin
      state     <= state_d;
      armed     <= 1'b1;
      rr_ptr    <= rr_d;
      gidx      <= gidx_d;
      nack      <= nack_d;
      r_grant   <= grant_d;
      r_done    <= done_d;
      r_err     <= err_d;
      m_go      <= go_d;
      m_rw      <= rw_d;
      m_nbyte   <= nbyte_d;
      m_dev_add <= dev_d;
      m_ptr     <= ptr_d;
`ifdef I2C_ARB_WDOG_EN
      wdog      <= wdog_d;
`endif
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: directed self-checking bench for i2c_arbiter (NREQ=4, WDOG_CYC=100).
// It includes a small behavioural I2C master model. The watchdog case runs only when
// I2C_ARB_WDOG_EN is defined.
module tb_i2c_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  r_req, r_rw;
  logic [23:0] r_nbyte;
  logic [27:0] r_dev_add;
  logic [31:0] r_ptr, r_dwr;
  logic [3:0]  r_grant, r_done;
  logic        r_err;
  logic [7:0]  r_drd;
  logic        m_go, m_rw;
  logic [5:0]  m_nbyte;
  logic [6:0]  m_dev_add;
  logic [7:0]  m_ptr, m_dwr;
  logic        m_ready, m_done, m_ack_e;
  logic [7:0]  m_drd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2c_arbiter #(.NREQ(4), .WDOG_CYC(100)) dut (
    .clk(clk), .reset(reset),
    .r_req(r_req), .r_rw(r_rw), .r_nbyte(r_nbyte), .r_dev_add(r_dev_add),
    .r_ptr(r_ptr), .r_dwr(r_dwr),
    .r_grant(r_grant), .r_done(r_done), .r_err(r_err), .r_drd(r_drd),
    .m_go(m_go), .m_rw(m_rw), .m_nbyte(m_nbyte), .m_dev_add(m_dev_add),
    .m_ptr(m_ptr), .m_dwr(m_dwr),
    .m_ready(m_ready), .m_done(m_done), .m_ack_e(m_ack_e), .m_drd(m_drd)
  );

  // Master model: m_done idles high, drops on accepting m_go, rises after nbyte+3 cycles
  logic       hang;
  logic [6:0] nack_dev;
  logic       busy, first, nack_now;
  logic [7:0] cnt;
  logic [7:0] last_dwr;

  assign m_drd = 8'hC3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ready <= 1'b1; m_done <= 1'b1; m_ack_e <= 1'b0;
      busy <= 1'b0; first <= 1'b0; nack_now <= 1'b0; cnt <= '0; last_dwr <= '0;
    end else begin
      m_ack_e <= 1'b0;
      if (!busy && m_go) begin
        busy <= 1'b1; m_ready <= 1'b0; m_done <= 1'b0; first <= 1'b1;
        cnt <= 8'(m_nbyte) + 8'd3;
        nack_now <= (m_dev_add == nack_dev);
      end else if (busy) begin
        if (first) begin
          m_ack_e  <= nack_now;
          last_dwr <= m_dwr;
          first    <= 1'b0;
        end
        if (!hang) begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            m_done <= 1'b1; m_ready <= 1'b1; busy <= 1'b0;
          end
        end
      end
    end
  end

  // Protocol monitors
  int viol = 0, goviol = 0, go_cnt = 0, done_cnt = 0;
  logic go_prev = 1'b0;
  always @(negedge clk) begin
    if ($countones(r_grant) > 1 || $countones(r_done) > 1) viol++;
    if (m_go && (!m_ready || go_prev)) goviol++;
    if (m_go) go_cnt++;
    if (r_done != 4'd0) done_cnt++;
    go_prev = m_go;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(output logic [3:0] d, output logic e);
    int n = 0;
    d = '0; e = 1'b0;
    while (n < 400) begin
      @(negedge clk);
      if (r_done != 4'd0) begin
        d = r_done; e = r_err;
        break;
      end
      n++;
    end
    chk("done_seen", 32'(|d), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  logic [3:0] d;
  logic       e;
  int         dc0, gc0, n;

  initial begin
    reset = 1'b0; r_req = '0; r_rw = 4'b1010;
    hang = 1'b0; nack_dev = 7'h00;
    for (int i = 0; i < 4; i++) begin
      r_nbyte[6*i +: 6]   = 6'(i + 1);
      r_dev_add[7*i +: 7] = 7'(8'h10 + i);
      r_ptr[8*i +: 8]     = 8'(8'h20 + i);
      r_dwr[8*i +: 8]     = 8'(8'h30 + i);
    end
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_grant", 32'(r_grant), 32'd0);
    chk("rst_done",  32'(r_done),  32'd0);
    chk("rst_err",   32'(r_err),   32'd0);
    chk("rst_go",    32'(m_go),    32'd0);

    // Single write transaction from requester 0, request held across reset release
    r_req = 4'b0001; r_nbyte[5:0] = 6'd2; r_rw[0] = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); chk("no_grant_1st_edge", 32'(r_grant), 32'd0);
    @(negedge clk); chk("grant_req0", 32'(r_grant), 32'd1);
    chk("go_not_with_grant", 32'(m_go), 32'd0);
    r_dev_add[6:0] = 7'h7F; r_nbyte[5:0] = 6'd9;
    @(negedge clk); chk("go_pulse", 32'(m_go), 32'd1);
    chk("go_dev_latched", 32'(m_dev_add), 32'h10);
    chk("go_nbyte_latched", 32'(m_nbyte), 32'd2);
    chk("go_rw", 32'(m_rw), 32'd0);
    chk("go_ptr", 32'(m_ptr), 32'h20);
    @(negedge clk); chk("go_one_cycle", 32'(m_go), 32'd0);
    r_dev_add[6:0] = 7'h10; r_nbyte[5:0] = 6'd2;
    wait_done(d, e);
    chk("done_req0", 32'(d), 32'd1);
    chk("err_req0", 32'(e), 32'd0);
    chk("dwr_mux", 32'(last_dwr), 32'h30);
    chk("drd_pass", 32'(r_drd), 32'hC3);
    r_req = '0;
    repeat (2) @(negedge clk);
    chk("grant_idle", 32'(r_grant), 32'd0);

    // Round-robin order with all four requesting from rr_ptr=0
    do_reset();
    r_req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_done(d, e);
      chk("rr_order", 32'(d), 32'(1 << (t % 4)));
      chk("rr_err", 32'(e), 32'd0);
    end
    r_req = '0;
    repeat (3) @(negedge clk);

    // NACK on requester 2; request dropped right after grant
    nack_dev = 7'h12;
    r_req = 4'b0100;
    @(negedge clk); chk("grant_req2", 32'(r_grant), 32'd4);
    r_req = '0;
    wait_done(d, e);
    chk("nack_done", 32'(d), 32'd4);
    chk("nack_err", 32'(e), 32'd1);
    nack_dev = 7'h00;
    repeat (2) @(negedge clk);

    // Zero-length command on requester 1
    r_nbyte[11:6] = 6'd0;
    gc0 = go_cnt;
    r_req = 4'b0010;
    @(negedge clk); chk("zl_grant", 32'(r_grant), 32'd2);
    @(negedge clk); chk("zl_done", 32'(r_done), 32'd2);
    chk("zl_err", 32'(r_err), 32'd1);
    r_req = '0;
    @(negedge clk); chk("zl_grant_clr", 32'(r_grant), 32'd0);
    chk("zl_no_go", 32'(go_cnt), 32'(gc0));
    r_nbyte[11:6] = 6'd2;
    repeat (2) @(negedge clk);

    // Reset while BUSY drops the grant without a done pulse
    r_nbyte[5:0] = 6'd8;
    r_req = 4'b0001;
    repeat (5) @(negedge clk);
    dc0 = done_cnt;
    reset = 1'b0;
    #1;
    chk("rstbusy_grant", 32'(r_grant), 32'd0);
    chk("rstbusy_go", 32'(m_go), 32'd0);
    chk("rstbusy_done", 32'(r_done), 32'd0);
    r_req = 4'b0100;
    repeat (3) @(negedge clk);
    chk("rstbusy_no_done", 32'(done_cnt), 32'(dc0));
    reset = 1'b1;
    wait_done(d, e);
    chk("post_rst_first", 32'(d), 32'd4);
    r_req = '0;
    repeat (3) @(negedge clk);

`ifdef I2C_ARB_WDOG_EN
    // Watchdog abort when the master never completes
    hang = 1'b1;
    r_req = 4'b0001;
    n = 0;
    while (n < 50 && !m_go) begin @(negedge clk); n++; end
    chk("wdog_go_seen", 32'(m_go), 32'd1);
    n = 0;
    while (n < 300) begin
      @(negedge clk); n++;
      if (r_done != 4'd0) break;
    end
    chk("wdog_cycles", 32'(n), 32'd100);
    chk("wdog_err", 32'(r_err), 32'd1);
    r_req = '0; hang = 1'b0;
    do_reset();
`endif

    chk("onehot_viol", 32'(viol), 32'd0);
    chk("go_viol", 32'(goviol), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
